// File: rtl/scan_fsm_pkg.sv
// Shared encodings for the speckle scan path: counter-control codes,
// FSM state encoding and the registered output bundle of scan_fsm.
package speckle_defs;

    // RAM address counter control: [4]=clear, [3]=increment, [2:0]=0
    localparam logic [4:0] CTRL_CLEAR = 5'b10000;
    localparam logic [4:0] CTRL_INC   = 5'b01000;
    localparam logic [4:0] CTRL_HOLD  = 5'b00000;

    localparam int CNT_W    = 5;   // row/col counter width (N <= 31)
    localparam int SAMPLE_W = 12;  // ADC sample width
    localparam int SETTLE_W = 8;   // settle counter width (SETTLE_CYCLES <= 255)

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ROW_SHIFT = 4'd1,
        ST_COL_SHIFT = 4'd2,
        ST_LATCH     = 4'd3,
        ST_SETTLE    = 4'd4,
        ST_CONVERT   = 4'd5,
        ST_WRITE     = 4'd6,
        ST_NEXT      = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

    // Every output of scan_fsm comes straight from one of these registers.
    typedef struct packed {
        logic                adc_start;
        logic [4:0]          col_ctrl;
        logic [4:0]          row_ctrl;
        logic                ram_wren;
        logic [SAMPLE_W-1:0] ram_data;
        logic                row_reg_data;
        logic                row_reg_write;
        logic                col_reg_data;
        logic                col_reg_write;
        logic                key_wren;
        logic                scan_end;
    } scan_out_t;

    // Output values while idle (and while held in reset).
    function automatic scan_out_t idle_outputs();
        scan_out_t o;
        o          = '0;
        o.col_ctrl = CTRL_CLEAR;
        o.row_ctrl = CTRL_CLEAR;
        return o;
    endfunction

endpackage

// File: rtl/scan_fsm_delay_counter.sv
// Loadable down-counter with zero flag; times the analog settle window.
module delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                cnt_q <= load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_fsm.sv
// Pixel-matrix scan sequencer: walks a one through the row/column shift
// registers, latches the key, waits for settling, runs one ADC conversion
// per pixel and writes the sample to RAM. Outputs are all registered.
module scan_fsm
    import speckle_defs::*;
#(
    parameter int N_ROWS        = 24,
    parameter int N_COLS        = 24,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                i_scan_go,
    output logic                o_adc_start,
    input  logic                i_adc_done,
    input  logic [SAMPLE_W-1:0] i_adc_data,
    output logic [4:0]          o_scan_col_control,
    output logic [4:0]          o_scan_row_control,
    output logic                o_scan_ram_wren,
    output logic [SAMPLE_W-1:0] o_scan_ram_data,
    output logic                o_scan_row_reg_data,
    output logic                o_scan_row_reg_write,
    output logic                o_scan_col_reg_data,
    output logic                o_scan_col_reg_write,
    output logic                o_scan_key_wren,
    output logic                o_signal_scan_end
);

    localparam logic [CNT_W-1:0]    ROW_LAST   = CNT_W'(N_ROWS - 1);
    localparam logic [CNT_W-1:0]    COL_LAST   = CNT_W'(N_COLS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                go_prev_q;
    scan_out_t           out_q, out_d;

    logic go_rise;
    logic settle_load;
    logic settle_dec;
    logic settle_zero;

    assign go_rise = i_scan_go & ~go_prev_q;

    // Settle window: loaded with SETTLE_CYCLES-1 on LATCH->SETTLE, so the
    // zero flag is seen on the last of exactly SETTLE_CYCLES SETTLE cycles.
    delay_counter #(
        .W(SETTLE_W)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (settle_dec),
        .zero_o     (settle_zero)
    );

    // State, counters, captured sample and go history; frozen while en=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            sample_q  <= '0;
            go_prev_q <= 1'b0;
            out_q     <= idle_outputs();
        end else if (en) begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            sample_q  <= sample_d;
            go_prev_q <= i_scan_go;
            out_q     <= out_d;
        end
    end

    // Next-state logic; losing the grant pre-empts every non-idle state.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        sample_d    = sample_q;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        if ((state_q != ST_IDLE) && !i_scan_go) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_rise) begin
                        state_d = ST_ROW_SHIFT;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                ST_ROW_SHIFT: state_d = ST_COL_SHIFT;
                ST_COL_SHIFT: state_d = ST_LATCH;
                ST_LATCH: begin
                    state_d     = ST_SETTLE;
                    settle_load = 1'b1;
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state_d = ST_CONVERT;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end
                ST_CONVERT: begin
                    // done is only honoured here; elsewhere it is ignored
                    if (i_adc_done) begin
                        sample_d = i_adc_data;
                        state_d  = ST_WRITE;
                    end
                end
                ST_WRITE: state_d = ST_NEXT;
                ST_NEXT: begin
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_COL_SHIFT;
                    end else begin
                        col_d = '0;
                        if (row_q < ROW_LAST) begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_ROW_SHIFT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output values for the state being entered, registered into out_q.
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_IDLE: out_d = idle_outputs();
            ST_ROW_SHIFT: begin
                out_d.row_reg_write = 1'b1;
                out_d.row_reg_data  = (row_d == '0);
            end
            ST_COL_SHIFT: begin
                out_d.col_reg_write = 1'b1;
                out_d.col_reg_data  = (col_d == '0);
            end
            ST_LATCH: out_d.key_wren = 1'b1;
            ST_CONVERT: out_d.adc_start = (state_q != ST_CONVERT);
            ST_WRITE: begin
                out_d.ram_wren = 1'b1;
                out_d.ram_data = sample_d;
                out_d.col_ctrl = CTRL_INC;
            end
            ST_NEXT: begin
                // End of a row: rewind RAM column, step RAM row unless last.
                if (col_q == COL_LAST) begin
                    out_d.col_ctrl = CTRL_CLEAR;
                    out_d.row_ctrl = (row_q < ROW_LAST) ? CTRL_INC : CTRL_HOLD;
                end
            end
            ST_DONE: out_d.scan_end = 1'b1;
            default: out_d = idle_outputs();
        endcase
    end

    assign o_adc_start          = out_q.adc_start;
    assign o_scan_col_control   = out_q.col_ctrl;
    assign o_scan_row_control   = out_q.row_ctrl;
    assign o_scan_ram_wren      = out_q.ram_wren;
    assign o_scan_ram_data      = out_q.ram_data;
    assign o_scan_row_reg_data  = out_q.row_reg_data;
    assign o_scan_row_reg_write = out_q.row_reg_write;
    assign o_scan_col_reg_data  = out_q.col_reg_data;
    assign o_scan_col_reg_write = out_q.col_reg_write;
    assign o_scan_key_wren      = out_q.key_wren;
    assign o_signal_scan_end    = out_q.scan_end;

endmodule

// File: doc/scan_fsm.md
SCAN_FSM -- requirements
Module: scan_fsm

Interface
REQ-001 SHALL have parameter N_ROWS, default 24, rows in pixel matrix (1..31).
REQ-002 SHALL have parameter N_COLS, default 24, columns in pixel matrix (1..31).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, wait cycles after key_wren before conversion (1..255).
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: en  in  1  clock enable; i_scan_go  in  1  grant/start level from top-level arbiter.
REQ-006 SHALL have ports: o_adc_start  out  1  conversion start pulse; i_adc_done  in  1  conversion complete pulse; i_adc_data  in  12  sample.
REQ-007 SHALL have ports: o_scan_col_control, o_scan_row_control  out  5  RAM address counter control ([4]=clear, [3]=increment, [2:0]=0).
REQ-008 SHALL have ports: o_scan_ram_wren  out  1; o_scan_ram_data  out  12.
REQ-009 SHALL have ports: o_scan_row_reg_data, o_scan_row_reg_write, o_scan_col_reg_data, o_scan_col_reg_write, o_scan_key_wren  out  1 each  chip shift-register drive.
REQ-010 SHALL have port: o_signal_scan_end  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL advance state only when en=1; all outputs registered (Moore).
REQ-012 SHALL implement states IDLE, ROW_SHIFT, COL_SHIFT, LATCH, SETTLE, CONVERT, WRITE, NEXT, DONE.
REQ-013 IDLE: counter controls 5'b10000, all other outputs 0; rising edge of i_scan_go -> ROW_SHIFT with row=0, col=0.
REQ-014 ROW_SHIFT: one cycle, row_reg_write=1, row_reg_data=1 if row==0 else 0 (walking one) -> COL_SHIFT.
REQ-015 COL_SHIFT: one cycle, col_reg_write=1, col_reg_data=1 if col==0 else 0 -> LATCH.
REQ-016 LATCH: one cycle key_wren=1 -> SETTLE; SETTLE holds exactly SETTLE_CYCLES cycles -> CONVERT.
REQ-017 CONVERT: o_adc_start=1 on first cycle only; wait for i_adc_done; same-cycle i_adc_done captures i_adc_data -> WRITE.
REQ-018 WRITE: one cycle ram_wren=1, ram_data=captured sample, col_control=5'b01000 -> NEXT.
REQ-019 NEXT: if col<N_COLS-1 then col+1, -> COL_SHIFT; else col=0, row_control=5'b01000, col_control=5'b10000; if row<N_ROWS-1 then row+1, -> ROW_SHIFT; else -> DONE.
REQ-020 DONE: o_signal_scan_end=1 for exactly one cycle, then IDLE; new scan requires i_scan_go low then high.
REQ-021 i_scan_go falling in any non-IDLE state SHALL abort to IDLE next enabled cycle, no scan_end, no further ram_wren.
REQ-022 i_adc_done outside CONVERT SHALL be ignored; i_adc_data sampled only with i_adc_done in CONVERT.
REQ-023 Row/col counters 5 bits, never exceed N-1; exactly N_ROWS*N_COLS ram_wren pulses per full scan.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, row=col=0, sample=0, all outputs to IDLE values (controls 5'b10000, rest 0); reset mid-scan discards progress.

Structure
REQ-025 Counter-control encodings (CTRL_CLEAR=5'b10000, CTRL_INC=5'b01000, CTRL_HOLD=5'b00000) and state encodings SHALL live in shared package/include speckle_defs.
REQ-026 SETTLE wait counter SHALL be a sub-module delay_counter (load, count-down, zero flag).

Verification
REQ-027 N_ROWS=2, N_COLS=3, SETTLE_CYCLES=4, adc_done 3 cycles after start, data=row*16+col -> 6 ram_wren with data 0,1,2,16,17,18, one scan_end.
REQ-028 Full scan default params -> 576 ram_wren, 24 row_reg_write (data=1 only first), 576 col_reg_write (data=1 at col 0), 23 row INC.
REQ-029 i_scan_go dropped during 2nd CONVERT -> IDLE next cycle, 1 ram_wren total, no scan_end.
REQ-030 rst=0 during SETTLE -> outputs at IDLE values immediately; after release and go edge, scan restarts at row 0 col 0.
REQ-031 Spurious i_adc_done in SETTLE and en=0 stall in CONVERT -> no capture, sequence resumes unchanged, scan_end still exactly once.
